// File: rtl/pea_request_arbiter.sv
// Round-robin arbiter sharing one polynomial evaluation core between NUM_REQ
// requesters; the core is granted for a whole instruction/data/result transaction.
module pea_request_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_empty_instruction,
    input  logic [NUM_REQ*WIDTH-1:0] req_instruction,
    output logic [NUM_REQ-1:0]       req_read_enable_instruction,
    input  logic [NUM_REQ-1:0]       req_empty_data,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_read_enable_data,
    input  logic [NUM_REQ-1:0]       req_full_result,
    output logic [WIDTH-1:0]         req_result,
    output logic [NUM_REQ-1:0]       req_write_enable_result,
    output logic                     core_empty_instruction,
    output logic [WIDTH-1:0]         core_instruction,
    input  logic                     core_read_enable_instruction,
    output logic                     core_empty_data,
    output logic [WIDTH-1:0]         core_data,
    input  logic                     core_read_enable_data,
    output logic                     core_full_result,
    input  logic [WIDTH-1:0]         core_result,
    input  logic                     core_write_enable_result,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, INSTR, DATA, RESULT} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;

    logic [WIDTH-1:0] instr_w [NUM_REQ];
    logic [WIDTH-1:0] data_w  [NUM_REQ];

    // Split the packed per-requester head words into indexable slices
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign instr_w[i] = req_instruction[i*WIDTH +: WIDTH];
        assign data_w[i]  = req_data[i*WIDTH +: WIDTH];
    end

    // First requester with a pending instruction, searching upward from rr_ptr
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand = IDX_W'((32'(rr_ptr) + k - 32'd1) % NUM_REQ);
            if (!req_empty_instruction[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // State register and grant bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            count  <= count_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

    // Next state, core-side FIFO views and gated requester enables
    always_comb begin
        state_nxt                   = state;
        grant_nxt                   = grant;
        owner_nxt                   = owner;
        rr_ptr_nxt                  = rr_ptr;
        count_nxt                   = count;
        core_empty_instruction      = 1'b1;
        core_empty_data             = 1'b1;
        core_full_result            = 1'b1;
        core_instruction            = '0;
        core_data                   = '0;
        req_result                  = '0;
        req_read_enable_instruction = '0;
        req_read_enable_data        = '0;
        req_write_enable_result     = '0;

        if (state != IDLE) begin
            core_instruction = instr_w[owner];
            core_data        = data_w[owner];
            req_result       = core_result;
        end

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt = NUM_REQ'(1) << pick;
                    owner_nxt = pick;
                    state_nxt = INSTR;
                end
            end
            INSTR: begin
                core_empty_instruction = req_empty_instruction[owner];
                if (core_read_enable_instruction && !req_empty_instruction[owner]) begin
                    req_read_enable_instruction = NUM_REQ'(1) << owner;
                    count_nxt = instr_w[owner][CNT_W-1:0];
                    state_nxt = (instr_w[owner][CNT_W-1:0] != '0) ? DATA : RESULT;
                end
            end
            DATA: begin
                core_empty_data = req_empty_data[owner] | (count == '0);
                if (core_read_enable_data && !req_empty_data[owner] && (count != '0)) begin
                    req_read_enable_data = NUM_REQ'(1) << owner;
                    count_nxt = count - CNT_W'(1);
                    if (count == CNT_W'(1)) state_nxt = RESULT;
                end
            end
            RESULT: begin
                core_full_result = req_full_result[owner];
                if (core_write_enable_result && !req_full_result[owner]) begin
                    req_write_enable_result = NUM_REQ'(1) << owner;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pea_request_arbiter.sv
// Randomized bench for pea_request_arbiter: FIFO and core models plus a
// transaction-level reference (round-robin order, word routing, result checksum).
module tb_pea_request_arbiter;

    localparam int unsigned N = 2;
    localparam int unsigned W = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_empty_instruction, req_read_enable_instruction;
    logic [N*W-1:0] req_instruction, req_data;
    logic [N-1:0]   req_empty_data, req_read_enable_data;
    logic [N-1:0]   req_full_result, req_write_enable_result;
    logic [W-1:0]   req_result, core_instruction, core_data, core_result;
    logic           core_empty_instruction, core_read_enable_instruction;
    logic           core_empty_data, core_read_enable_data;
    logic           core_full_result, core_write_enable_result;
    logic [N-1:0]   grant;
    logic           busy;

    pea_request_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .req_empty_instruction(req_empty_instruction), .req_instruction(req_instruction),
        .req_read_enable_instruction(req_read_enable_instruction),
        .req_empty_data(req_empty_data), .req_data(req_data),
        .req_read_enable_data(req_read_enable_data),
        .req_full_result(req_full_result), .req_result(req_result),
        .req_write_enable_result(req_write_enable_result),
        .core_empty_instruction(core_empty_instruction), .core_instruction(core_instruction),
        .core_read_enable_instruction(core_read_enable_instruction),
        .core_empty_data(core_empty_data), .core_data(core_data),
        .core_read_enable_data(core_read_enable_data),
        .core_full_result(core_full_result), .core_result(core_result),
        .core_write_enable_result(core_write_enable_result),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Environment state
    logic [W-1:0] q_instr [N][$];
    logic [W-1:0] q_data  [N][$];
    bit           gen_on, stall_on;
    logic [W-1:0] acc;

    // Reference model state
    int           rr_m, owner_m, exp_n, remaining, ipops, dpops;
    bit           active, released_prev;
    logic [W-1:0] exp_res;
    logic [N-1:0] prev_grant, prev_iempty;
    int           generated, completed;

    function automatic logic [W-1:0] mix(input logic [W-1:0] a, input logic [W-1:0] d);
        return a * 32'd31 + d;
    endfunction

    task automatic flush_model();
        for (int i = 0; i < int'(N); i++) begin
            q_instr[i].delete();
            q_data[i].delete();
        end
        rr_m = 0; active = 0; released_prev = 0; acc = '0;
        prev_grant = '0; prev_iempty = '1;
    endtask

    task automatic add_txn(input int r, input int n);
        logic [W-1:0] w;
        w = $urandom;
        w[3:0] = 4'(n);
        q_instr[r].push_back(w);
        for (int k = 0; k < n; k++) q_data[r].push_back($urandom);
        generated++;
    endtask

    // One clock cycle: drive, settle, check/update model, advance
    task automatic step();
        int           idx;
        logic [N-1:0] exp_g;
        if (gen_on)
            for (int i = 0; i < int'(N); i++)
                if ($urandom_range(0, 7) == 0 && q_instr[i].size() < 3)
                    add_txn(i, ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 4)));
        for (int i = 0; i < int'(N); i++) begin
            req_empty_instruction[i] = (q_instr[i].size() == 0) || (stall_on && $urandom_range(0, 9) == 0);
            req_empty_data[i]        = (q_data[i].size() == 0) || (stall_on && $urandom_range(0, 3) == 0);
            req_full_result[i]       = stall_on && ($urandom_range(0, 9) < 3);
            req_instruction[i*W +: W] = (q_instr[i].size() != 0) ? q_instr[i][0] : '0;
            req_data[i*W +: W]        = (q_data[i].size() != 0) ? q_data[i][0] : '0;
        end
        core_read_enable_instruction = ($urandom_range(0, 2) != 0);
        core_read_enable_data        = ($urandom_range(0, 2) != 0);
        core_write_enable_result     = ($urandom_range(0, 2) != 0);
        core_result                  = acc;
        #1;
        if (!reset) begin
            // Grant sequencing
            if (released_prev) begin
                check("grant_release", 64'(grant), 64'(0));
            end else if (prev_grant == '0) begin
                idx = -1;
                for (int k = 0; k < int'(N); k++)
                    if (idx < 0 && !prev_iempty[(rr_m + k) % int'(N)]) idx = (rr_m + k) % int'(N);
                exp_g = (idx >= 0) ? N'(1) << idx : '0;
                check("grant_pick", 64'(grant), 64'(exp_g));
                if (idx >= 0) begin
                    active = 1; owner_m = idx; ipops = 0; dpops = 0;
                    exp_n = int'(q_instr[idx][0][3:0]);
                    remaining = exp_n;
                    exp_res = q_instr[idx][0];
                    for (int k = 0; k < exp_n; k++) exp_res = mix(exp_res, q_data[idx][k]);
                end
            end else begin
                check("grant_hold", 64'(grant), 64'(prev_grant));
            end
            released_prev = 0;
            check("grant_onehot", 64'($onehot0(grant)), 64'(1));
            check("busy", 64'(busy), 64'(grant != '0));
            // Gating: only the owner, never on empty/full, matches the core's view
            check("ri_mask", 64'(req_read_enable_instruction & ~grant), 64'(0));
            check("rd_mask", 64'(req_read_enable_data & ~grant), 64'(0));
            check("wr_mask", 64'(req_write_enable_result & ~grant), 64'(0));
            check("ri_empty", 64'(req_read_enable_instruction & req_empty_instruction), 64'(0));
            check("rd_empty", 64'(req_read_enable_data & req_empty_data), 64'(0));
            check("wr_full", 64'(req_write_enable_result & req_full_result), 64'(0));
            check("ri_core", 64'(|req_read_enable_instruction),
                  64'(core_read_enable_instruction & ~core_empty_instruction));
            check("rd_core", 64'(|req_read_enable_data), 64'(core_read_enable_data & ~core_empty_data));
            check("wr_core", 64'(|req_write_enable_result),
                  64'(core_write_enable_result & ~core_full_result));
            if (grant == '0) begin
                check("idle_view", 64'({core_empty_instruction, core_empty_data, core_full_result}), 64'(3'b111));
                check("idle_words", 64'(core_instruction | core_data | req_result), 64'(0));
            end
            // Transaction accounting
            if (|req_read_enable_instruction) begin
                check("instr_once", 64'(ipops), 64'(0));
                ipops++;
            end
            if (|req_read_enable_data) begin
                check("data_after_instr", 64'(ipops), 64'(1));
                check("data_budget", 64'(remaining > 0), 64'(1));
                dpops++;
                if (remaining > 0) remaining--;
            end
            if (|req_write_enable_result) begin
                check("res_target", 64'(req_write_enable_result), 64'(N'(1) << owner_m));
                check("res_value", 64'(req_result), 64'(exp_res));
                check("res_ipops", 64'(ipops), 64'(1));
                check("res_dpops", 64'(dpops), 64'(exp_n));
                completed++;
                active = 0;
                released_prev = 1;
                rr_m = (owner_m + 1) % int'(N);
            end
            // Core model: consumes words it was allowed to read
            if (core_read_enable_instruction && !core_empty_instruction) acc = core_instruction;
            if (core_read_enable_data && !core_empty_data) acc = mix(acc, core_data);
            if (core_write_enable_result && !core_full_result) acc = '0;
            for (int i = 0; i < int'(N); i++) begin
                if (req_read_enable_instruction[i] && q_instr[i].size() != 0) void'(q_instr[i].pop_front());
                if (req_read_enable_data[i] && q_data[i].size() != 0) void'(q_data[i].pop_front());
            end
            prev_grant  = grant;
            prev_iempty = req_empty_instruction;
        end
        @(posedge clock);
        #1;
        if (reset) flush_model();
    endtask

    initial begin
        int  bound;
        bit  pending;
        generated = 0; completed = 0;
        gen_on = 0; stall_on = 0;
        flush_model();
        reset = 1'b1;
        // Requests present during reset must not be granted
        add_txn(0, 1);
        add_txn(1, 0);
        repeat (3) step();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_view", 64'({core_empty_instruction, core_empty_data, core_full_result}), 64'(3'b111));
        generated = 0;
        reset = 1'b0;

        // Both requesters loaded from reset, then randomized traffic with stalls
        add_txn(0, 3);
        add_txn(1, 0);
        add_txn(0, 0);
        add_txn(1, 2);
        gen_on = 1; stall_on = 1;
        repeat (4000) step();

        // Drain
        gen_on = 0; stall_on = 0;
        bound = 0;
        do begin
            step();
            bound++;
            pending = active || grant != '0;
            for (int i = 0; i < int'(N); i++) pending |= (q_instr[i].size() != 0);
        end while (pending && bound < 3000);
        check("drain_done", 64'(pending), 64'(0));
        check("txn_count", 64'(completed), 64'(generated));

        // Reset asserted mid-DATA
        add_txn(1, 3);
        bound = 0;
        while (!(active && dpops >= 1) && bound < 200) begin
            step();
            bound++;
        end
        check("reach_data", 64'(active && dpops >= 1), 64'(1));
        reset = 1'b1;
        step();
        check("mid_rst_grant", 64'(grant), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_en", 64'({req_read_enable_instruction, req_read_enable_data, req_write_enable_result}), 64'(0));
        check("mid_rst_view", 64'({core_empty_instruction, core_empty_data, core_full_result}), 64'(3'b111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
